// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state, IO region tag and burst length width for mem_io_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  localparam logic [1:0] IO_REGION = 2'b11;
  localparam int LEN_W = 2;
endpackage

// File: rtl/mem_io_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first active request at or after ptr
module rr_arbiter #(
  parameter int NM = 2,
  parameter int PW = 1
) (
  input  logic [NM-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NM-1:0] grant,
  output logic [PW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int k = NM - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NM]) idx = PW'((int'(ptr) + k) % NM);
    any = |req;
    grant = any ? NM'(1) << idx : '0;
  end
endmodule

// File: rtl/mem_io_arbiter.sv
// mem_io_arbiter: round-robin byte-burst arbiter to RAM/IO with debug override; MEM_ARB_PERF_EN adds per-master byte counters
module mem_io_arbiter import mem_arb_pkg::*; #(
  parameter int NUM_MASTERS    = 2,
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [NUM_MASTERS-1:0]      m_req,
  input  logic [NUM_MASTERS*32-1:0]   m_addr,
  input  logic [NUM_MASTERS-1:0]      m_wr,
  input  logic [NUM_MASTERS*2-1:0]    m_len,
  input  logic [NUM_MASTERS*32-1:0]   m_wdata,
  output logic [NUM_MASTERS-1:0]      m_rvalid,
  output logic [7:0]                  m_rdata,
  output logic [NUM_MASTERS-1:0]      m_done,
  input  logic                        dbg_active,
  input  logic [RAM_ADDR_WIDTH-1:0]   dbg_a,
  input  logic                        dbg_wr,
  input  logic [7:0]                  dbg_dout,
  output logic [7:0]                  dbg_din,
  output logic                        ram_en,
  output logic                        ram_wr,
  output logic [RAM_ADDR_WIDTH-1:0]   ram_a,
  output logic [7:0]                  ram_din,
  input  logic [7:0]                  ram_dout,
  output logic                        io_en,
  output logic                        io_wr,
  output logic [2:0]                  io_sel,
  output logic [7:0]                  io_din,
  input  logic [7:0]                  io_dout,
  input  logic                        io_full,
  output logic [NUM_MASTERS*32-1:0]   perf_bytes
);
  localparam int NM  = NUM_MASTERS;
  localparam int RAW = RAM_ADDR_WIDTH;
  localparam int PW  = (NM > 1) ? $clog2(NM) : 1;
  state_t state, state_nx;
  logic [PW-1:0] ptr, owner, win, q_owner;
  logic [NM-1:0] grant, own_oh;
  logic [31:0] addr, wdata, cur;
  logic [LEN_W-1:0] len, cnt;
  logic wr, any, accept, issue, is_io, q_valid, q_io, unused_hi;
  rr_arbiter #(.NM(NM), .PW(PW)) u_rr (.req(m_req), .ptr(ptr), .grant(grant), .idx(win), .any(any));
  assign cur       = addr + 32'(cnt);
  assign unused_hi = ^cur[31:RAW+1];
  assign is_io     = cur[RAW:RAW-1] == IO_REGION;
  assign accept    = state == IDLE && any && !dbg_active;
  // A full IO write buffer stalls only writes; the byte counter holds until it drains
  assign issue     = state == BUSY && !dbg_active && !(is_io && wr && io_full);
  assign m_rvalid  = q_valid ? NM'(1) << q_owner : '0;
  assign m_rdata   = q_valid ? (q_io ? io_dout : ram_dout) : '0;
  assign m_done    = state == DRAIN ? own_oh : '0;
  assign dbg_din   = ram_dout;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = BUSY;
    else if (state == BUSY && issue && cnt == len) state_nx = DRAIN;
    else if (state == DRAIN) state_nx = IDLE;
  end
  always_comb begin
    ram_en = 1'b0;
    ram_wr = 1'b0;
    ram_a = '0;
    ram_din = '0;
    io_en = 1'b0;
    io_wr = 1'b0;
    io_sel = '0;
    io_din = '0;
    if (dbg_active) begin
      ram_en = 1'b1;
      ram_wr = dbg_wr;
      ram_a = dbg_a;
      ram_din = dbg_dout;
    end else if (issue) begin
      ram_en = !is_io;
      ram_wr = !is_io && wr;
      ram_a = is_io ? '0 : cur[RAW-1:0];
      ram_din = is_io ? '0 : wdata[{cnt, 3'b000} +: 8];
      io_en = is_io;
      io_wr = is_io && wr;
      io_sel = is_io ? cur[2:0] : '0;
      io_din = is_io ? wdata[{cnt, 3'b000} +: 8] : '0;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      own_oh <= '0;
      addr <= '0;
      wr <= 1'b0;
      len <= '0;
      wdata <= '0;
      cnt <= '0;
      q_valid <= 1'b0;
      q_io <= 1'b0;
      q_owner <= '0;
    end else begin
      state <= state_nx;
      q_valid <= issue && !wr;
      q_io <= is_io;
      q_owner <= owner;
      if (accept) begin
        owner <= win;
        own_oh <= grant;
        addr <= m_addr[int'(win)*32 +: 32];
        wr <= m_wr[win];
        len <= m_len[int'(win)*LEN_W +: LEN_W];
        wdata <= m_wdata[int'(win)*32 +: 32];
        cnt <= '0;
        ptr <= (win == PW'(NM - 1)) ? '0 : win + 1'b1;
      end else if (issue && cnt != len) cnt <= cnt + 1'b1;
    end
  end
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf [NM];
  always_ff @(posedge clk_in) begin
    if (rst_in) for (int k = 0; k < NM; k++) perf[k] <= '0;
    else if (issue) perf[owner] <= perf[owner] + 1'b1;
  end
  for (genvar i = 0; i < NM; i++) assign perf_bytes[i*32 +: 32] = perf[i];
`else
  assign perf_bytes = '0;
`endif
endmodule
